adder_seq_ctrl: RTL and testbench



---
 rtl/adder_seq_pkg.sv | 17 +
 rtl/adder_seq_ctrl_edge_rise.sv | 19 +
 rtl/adder_seq_ctrl.sv | 115 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and sizes for the five-operand sequential adder.
// Imported by the controller and its edge detectors.
package adder_seq_pkg;

  localparam int W_OP   = 4;
  localparam int N_SLOT = 4;
  localparam int N_OPS  = 5;
  localparam int W_ACC  = 7;
  localparam int W_IDX  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

endpackage

// File: rtl/adder_seq_ctrl_edge_rise.sv
// Registered rising-edge detector.
// The output is high for one cycle when d goes from low to high.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencer for the five-operand adder: loads slots from pushbuttons,
// then serially sums slots plus a snapshot of t through one adder.
module adder_seq_ctrl
  import adder_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic       ROT_SWITCH,
  input  logic [3:0] t,
  output logic [5:0] sum,
  output logic       cout,
  output logic       busy,
  output logic       valid
);

  logic [N_SLOT-1:0] pb_in;
  logic [N_SLOT-1:0] pb_ev;
  logic              rot_ev;

  state_e            state_q, state_d;
  logic [W_OP-1:0]   slot_q [N_SLOT];
  logic [W_OP-1:0]   slot_d [N_SLOT];
  logic [W_OP-1:0]   snap_q, snap_d;
  logic [W_ACC-1:0]  acc_q, acc_d;
  logic [W_IDX-1:0]  idx_q, idx_d;
  logic [5:0]        sum_q, sum_d;
  logic              cout_q, cout_d;
  logic [W_OP-1:0]   op;
  logic [W_ACC-1:0]  add;

  assign pb_in = {PB4, PB3, PB2, PB1};

  for (genvar k = 0; k < N_SLOT; k++) begin : g_pb
    edge_rise u_pb (
      .clk  (clk),
      .rst  (rst),
      .d    (pb_in[k]),
      .rise (pb_ev[k])
    );
  end

  edge_rise u_rot (
    .clk  (clk),
    .rst  (rst),
    .d    (ROT_SWITCH),
    .rise (rot_ev)
  );

  // operand 4 is the snapshot of t taken at start
  assign op  = (idx_q == W_IDX'(N_SLOT)) ? snap_q : slot_q[idx_q[1:0]];
  assign add = acc_q + W_ACC'(op);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        for (int k = 0; k < N_SLOT; k++) begin
          if (pb_ev[k]) slot_d[k] = t;
        end
        if (rot_ev) begin
          state_d = ACC;
          acc_d   = '0;
          snap_d  = t;
          idx_d   = '0;
        end
      end
      ACC: begin
        acc_d = add;
        idx_d = idx_q + W_IDX'(1);
        if (idx_q == W_IDX'(N_OPS - 1)) begin
          state_d         = DONE;
          {cout_d, sum_d} = add;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int k = 0; k < N_SLOT; k++) slot_q[k] <= '0;
      snap_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < N_SLOT; k++) slot_q[k] <= slot_d[k];
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum   = sum_q;
  assign cout  = cout_q;
  assign busy  = (state_q != IDLE);
  assign valid = (state_q == DONE);

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl.
// Each task drives one scenario and checks inline.
module tb_adder_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       PB1 = 1'b0;
  logic       PB2 = 1'b0;
  logic       PB3 = 1'b0;
  logic       PB4 = 1'b0;
  logic       ROT_SWITCH = 1'b0;
  logic [3:0] t = 4'd0;
  logic [5:0] sum;
  logic       cout;
  logic       busy;
  logic       valid;

  int errors = 0;
  int checks = 0;

  adder_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .PB1        (PB1),
    .PB2        (PB2),
    .PB3        (PB3),
    .PB4        (PB4),
    .ROT_SWITCH (ROT_SWITCH),
    .t          (t),
    .sum        (sum),
    .cout       (cout),
    .busy       (busy),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] mask, input logic [3:0] val);
    t   = val;
    PB1 = mask[0];
    PB2 = mask[1];
    PB3 = mask[2];
    PB4 = mask[3];
    tick();
    PB1 = 1'b0;
    PB2 = 1'b0;
    PB3 = 1'b0;
    PB4 = 1'b0;
    tick();
  endtask

  // mode 0 plain, 1 PB2 pulse mid-run, 2 ROT pulse mid-run, 3 ROT held
  task automatic run(input string name, input logic [3:0] tval,
                     input int mode, input logic [6:0] exp);
    int nval;
    int first;
    logic [6:0] got;
    nval  = 0;
    first = -1;
    got   = '0;
    t = tval;
    ROT_SWITCH = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_e0: got %b want 1", name, busy);
    end
    for (int i = 1; i <= 20; i++) begin
      if (i == 1 && mode != 3) ROT_SWITCH = 1'b0;
      if (mode == 1 && i == 2) begin PB2 = 1'b1; t = 4'd15; end
      if (mode == 1 && i == 3) PB2 = 1'b0;
      if (mode == 2 && i == 2) ROT_SWITCH = 1'b1;
      if (mode == 2 && i == 3) ROT_SWITCH = 1'b0;
      tick();
      if (valid === 1'b1) begin
        nval++;
        if (first < 0) begin
          first = i;
          got   = {cout, sum};
        end
      end
    end
    ROT_SWITCH = 1'b0;
    tick();
    checks++;
    if (nval != 1) begin
      errors++;
      $display("FAIL %s valid_count: got %0d want 1", name, nval);
    end
    checks++;
    if (first != 5) begin
      errors++;
      $display("FAIL %s latency: got %0d want 5", name, first);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s result: got %0d want %0d", name, got, exp);
    end
    checks++;
    if ({cout, sum} !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s hold: got %0d busy %b want %0d busy 0",
               name, {cout, sum}, busy, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({cout, sum, busy, valid} !== 9'd0) begin
      errors++;
      $display("FAIL reset: got %b want 0", {cout, sum, busy, valid});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy %b valid %b want 0 0",
               busy, valid);
    end
  endtask

  task automatic test_basic();
    load(4'b0001, 4'd3);
    load(4'b0010, 4'd5);
    load(4'b0100, 4'd7);
    load(4'b1000, 4'd9);
    run("basic", 4'd11, 0, 7'd35);
  endtask

  task automatic test_max();
    load(4'b1111, 4'd15);
    run("max", 4'd15, 0, 7'd75);
    tick();
    tick();
    checks++;
    if (cout !== 1'b1 || sum !== 6'b001011) begin
      errors++;
      $display("FAIL max_hold: got %b %b want 1 001011", cout, sum);
    end
  endtask

  task automatic test_simul();
    load(4'b0101, 4'd6);
    load(4'b1010, 4'd0);
    run("simul", 4'd0, 0, 7'd12);
  endtask

  task automatic test_discard();
    run("pb_busy", 4'd0, 1, 7'd12);
    run("pb_busy_rerun", 4'd0, 0, 7'd12);
    run("rot_busy", 4'd0, 2, 7'd12);
    run("rot_held", 4'd0, 3, 7'd12);
  endtask

  task automatic test_reset_mid();
    t = 4'd9;
    ROT_SWITCH = 1'b1;
    tick();
    ROT_SWITCH = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({cout, sum, busy, valid} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid: got %b want 0",
               {cout, sum, busy, valid});
    end
    tick();
    rst = 1'b0;
    tick();
    run("after_reset", 4'd4, 0, 7'd4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_simul();
    test_discard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
